// File: rtl/sysbus_mem_responder_if.sv
// Sysbus initiator/responder handshake bundle: request path (reqcyc/req/reqtag/reqack)
// and response path (respcyc/resp/resptag/respack).
interface sysbus_mem_responder_if #(
    parameter int unsigned TAG_W = 13
);
    logic             reqcyc;
    logic [63:0]      req;
    logic [TAG_W-1:0] reqtag;
    logic             reqack;
    logic             respcyc;
    logic [63:0]      resp;
    logic [TAG_W-1:0] resptag;
    logic             respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: 64-byte line reads/writes as 8 x 64-bit beats from a word array.
// Optional SYSBUS_MMIO_HOLE_EN: lines in [0xA0000, 0x100000) read as zero and drop writes.
module sysbus_mem_responder #(
    parameter int unsigned MEM_WORDS = 8192,
    parameter int unsigned READ_LAT  = 4,
    parameter int unsigned TAG_W     = 13
) (
    input logic                   clk,
    input logic                   reset,
    sysbus_mem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        RD_LAT,
        RD_RESP,
        WR_DATA
    } state_e;

    state_e           state_q, state_d;
    logic             reqack_q, reqack_d;
    logic             respcyc_q, respcyc_d;
    logic [63:0]      resp_q, resp_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [2:0]       beat_q, beat_d;
    logic [3:0]       lat_q, lat_d;
    logic [AW-1:0]    base_q, base_d;

    logic [63:0]      mem [MEM_WORDS];
    logic             mem_we;
    logic [AW-1:0]    cur_idx;
    logic             accept_hdr;
    logic             hole;

    // A beat is taken only while reqack is low, so the ack cycle itself never
    // consumes the value the initiator is still holding from the previous beat.
    assign accept_hdr = (state_q == IDLE) && bus.reqcyc && !reqack_q;
    assign cur_idx    = base_q + AW'(beat_q);

`ifdef SYSBUS_MMIO_HOLE_EN
    logic mmio_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mmio_q <= 1'b0;
        end else if (accept_hdr) begin
            mmio_q <= (bus.req >= 64'h0000_0000_000A_0000) && (bus.req < 64'h0000_0000_0010_0000);
        end
    end
    assign hole = mmio_q;
`else
    assign hole = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            base_q    <= '0;
        end else begin
            state_q   <= state_d;
            reqack_q  <= reqack_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            tag_q     <= tag_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            base_q    <= base_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_idx] <= bus.req;
        end
    end

    always_comb begin
        state_d   = state_q;
        reqack_d  = 1'b0;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        tag_d     = tag_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        base_d    = base_q;
        mem_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept_hdr) begin
                    reqack_d = 1'b1;
                    tag_d    = bus.reqtag;
                    base_d   = bus.req[3 +: AW] & ~AW'(7);
                    beat_d   = '0;
                    lat_d    = '0;
                    state_d  = bus.reqtag[TAG_W-1] ? RD_LAT : WR_DATA;
                end
            end
            RD_LAT: begin
                if (lat_q == 4'(READ_LAT - 1)) begin
                    lat_d     = '0;
                    respcyc_d = 1'b1;
                    resp_d    = hole ? '0 : mem[base_q];
                    state_d   = RD_RESP;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            RD_RESP: begin
                if (bus.respack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        respcyc_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        resp_d = hole ? '0 : mem[cur_idx + AW'(1)];
                    end
                end
            end
            WR_DATA: begin
                if (bus.reqcyc && !reqack_q) begin
                    reqack_d = 1'b1;
                    mem_we   = !hole;
                    beat_d   = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.reqack  = reqack_q;
    assign bus.respcyc = respcyc_q;
    assign bus.resp    = resp_q;
    assign bus.resptag = tag_q;
endmodule
